// File: rtl/snake_engine.sv
// snake_engine
//   Snake game core: keeps the snake body, applies one move per tick, detects
//   wall and self collisions, grows on eating and places new food from a
//   10-bit LFSR.
//
// Ports
//   clk                        system clock, all state on rising edge
//   rst                        asynchronous active-high reset
//   tick                       one-cycle move strobe (RUNNING only)
//   dir_in / dir_valid         requested direction UP=00 DOWN=01 RIGHT=10 LEFT=11
//   start                      start (INITIAL) / restart (DIE) strobe
//   food_x, food_y             food cell
//   snake_x_1dim, snake_y_1dim segment i at bits [5i+4:5i], i=0 is the head;
//                              inactive segments read 0
//   snake_length               active segment count
//   game_state                 RUNNING=00 DIE=01 INITIAL=10
//
// Build option
//   SNAKE_WRAP_EN  defined: the head wraps to the opposite edge, no wall death.
//                  undefined: leaving the grid kills the snake.
//
// States
//   ST_INITIAL | snake parked at its reset position, waiting for start
//   ST_RUNNING | ticks move the snake
//   ST_DIE     | collision seen, body frozen, waiting for start
module snake_engine #(
  parameter int GRID_W   = 32,
  parameter int GRID_H   = 24,
  parameter int INIT_LEN = 3,
  parameter int MAX_LEN  = 63
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         tick,
  input  logic [1:0]   dir_in,
  input  logic         dir_valid,
  input  logic         start,
  output logic [4:0]   food_x,
  output logic [4:0]   food_y,
  output logic [319:0] snake_x_1dim,
  output logic [319:0] snake_y_1dim,
  output logic [5:0]   snake_length,
  output logic [1:0]   game_state
);

  localparam int NSEG = 64;

  localparam logic [1:0] DIR_UP    = 2'b00;
  localparam logic [1:0] DIR_DOWN  = 2'b01;
  localparam logic [1:0] DIR_RIGHT = 2'b10;
  localparam logic [1:0] DIR_LEFT  = 2'b11;

  localparam int         HEAD_X0   = 16;
  localparam logic [4:0] HEAD_Y0   = 5'd12;
  localparam logic [4:0] FOOD_X0   = 5'd24;
  localparam logic [4:0] FOOD_Y0   = 5'd12;
  localparam logic [9:0] LFSR_SEED = 10'h2A5;

  typedef enum logic [1:0] {
    ST_RUNNING = 2'b00,
    ST_DIE     = 2'b01,
    ST_INITIAL = 2'b10
  } state_t;

  state_t state, state_nx;

  logic [4:0] seg_x [NSEG];
  logic [4:0] seg_y [NSEG];
  logic [5:0] len;
  logic [1:0] dir_applied;
  logic [1:0] dir_pending;
  logic       place_pend;
  logic [9:0] lfsr;

  logic       move;
  logic       move_ok;
  logic       restart;
  logic       wall;
  logic       eat;
  logic       grow;
  logic       self_hit;
  logic       collide;
  logic       dir_opposite;
  logic [4:0] nx;
  logic [4:0] ny;
  logic [4:0] cand_x;
  logic [4:0] cand_y;
  logic       cand_busy;

  function automatic logic [4:0] init_seg_x(int i);
    return (i < INIT_LEN) ? 5'(HEAD_X0 - i) : 5'd0;
  endfunction

  function automatic logic [4:0] init_seg_y(int i);
    return (i < INIT_LEN) ? HEAD_Y0 : 5'd0;
  endfunction

  // ---------------------------------------------------------------- FSM
  always_ff @(posedge clk or posedge rst) begin
    if (rst) state <= ST_INITIAL;
    else     state <= state_nx;
  end

  always_comb begin
    state_nx = state;
    case (state)
      ST_INITIAL: if (start)          state_nx = ST_RUNNING;
      ST_RUNNING: if (tick && collide) state_nx = ST_DIE;
      ST_DIE:     if (start)          state_nx = ST_INITIAL;
      default:                        state_nx = ST_INITIAL;
    endcase
  end

  assign game_state = state;
  assign move       = (state == ST_RUNNING) && tick;
  assign restart    = (state == ST_DIE) && start;

  // ---------------------------------------------------------- next head
  always_comb begin
    nx   = seg_x[0];
    ny   = seg_y[0];
    wall = 1'b0;
    case (dir_pending)
      DIR_UP: begin
        if (seg_y[0] == 5'd0) begin
`ifdef SNAKE_WRAP_EN
          ny = 5'(GRID_H - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          ny = seg_y[0] - 5'd1;
        end
      end
      DIR_DOWN: begin
        if (seg_y[0] == 5'(GRID_H - 1)) begin
`ifdef SNAKE_WRAP_EN
          ny = 5'd0;
`else
          wall = 1'b1;
`endif
        end else begin
          ny = seg_y[0] + 5'd1;
        end
      end
      DIR_RIGHT: begin
        if (seg_x[0] == 5'(GRID_W - 1)) begin
`ifdef SNAKE_WRAP_EN
          nx = 5'd0;
`else
          wall = 1'b1;
`endif
        end else begin
          nx = seg_x[0] + 5'd1;
        end
      end
      default: begin
        if (seg_x[0] == 5'd0) begin
`ifdef SNAKE_WRAP_EN
          nx = 5'(GRID_W - 1);
`else
          wall = 1'b1;
`endif
        end else begin
          nx = seg_x[0] - 5'd1;
        end
      end
    endcase
  end

  // The tail only vacates its cell when the snake does not grow, so it
  // counts as an obstacle only on an eating move.
  always_comb begin
    eat      = !place_pend && !wall && (nx == food_x) && (ny == food_y);
    self_hit = 1'b0;
    for (int i = 0; i < NSEG; i++) begin
      if (((i + 1 < int'(len)) || (eat && (i + 1 == int'(len)))) &&
          (seg_x[i] == nx) && (seg_y[i] == ny))
        self_hit = 1'b1;
    end
  end

  assign collide = wall || self_hit;
  assign move_ok = move && !collide;
  assign grow    = move_ok && eat && (len < 6'(MAX_LEN));

  // ------------------------------------------------------ food placement
  // Rows 24..31 of the raw LFSR field fold back onto rows 16..23.
  assign cand_x = lfsr[4:0];
  assign cand_y = (lfsr[9:5] >= 5'd24) ? (lfsr[9:5] - 5'd8) : lfsr[9:5];

  // The candidate is checked against the body as it will be after this
  // cycle, so a move and a placement may share the same cycle.
  always_comb begin
    int keep;
    keep = (move_ok && !grow) ? int'(len) - 1 : int'(len);
    cand_busy = move_ok && (nx == cand_x) && (ny == cand_y);
    for (int i = 0; i < NSEG; i++) begin
      if ((i < keep) && (seg_x[i] == cand_x) && (seg_y[i] == cand_y))
        cand_busy = 1'b1;
    end
  end

  // Opposite of the last applied move: same axis bit, different sign bit.
  assign dir_opposite = (dir_in[1] == dir_applied[1]) && (dir_in[0] != dir_applied[0]);

  // ------------------------------------------------------------ datapath
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      lfsr        <= LFSR_SEED;
      dir_applied <= DIR_RIGHT;
      dir_pending <= DIR_RIGHT;
      place_pend  <= 1'b0;
      len         <= 6'(INIT_LEN);
      food_x      <= FOOD_X0;
      food_y      <= FOOD_Y0;
      for (int i = 0; i < NSEG; i++) begin
        seg_x[i] <= init_seg_x(i);
        seg_y[i] <= init_seg_y(i);
      end
    end else begin
      // x^10 + x^7 + 1, free-running
      lfsr <= {lfsr[8:0], lfsr[9] ^ lfsr[6]};
      if (restart) begin
        dir_applied <= DIR_RIGHT;
        dir_pending <= DIR_RIGHT;
        place_pend  <= 1'b0;
        len         <= 6'(INIT_LEN);
        food_x      <= FOOD_X0;
        food_y      <= FOOD_Y0;
        for (int i = 0; i < NSEG; i++) begin
          seg_x[i] <= init_seg_x(i);
          seg_y[i] <= init_seg_y(i);
        end
      end else begin
        if (move) dir_applied <= dir_pending;
        if (move_ok) begin
          // The whole array shifts; the growth tail is simply old seg[len-1]
          // landing at seg[len].
          for (int i = NSEG - 1; i > 0; i--) begin
            seg_x[i] <= seg_x[i-1];
            seg_y[i] <= seg_y[i-1];
          end
          seg_x[0] <= nx;
          seg_y[0] <= ny;
          if (grow) len <= len + 6'd1;
        end
        // eat requires !place_pend, so these two never collide
        if (move_ok && eat) begin
          place_pend <= 1'b1;
        end else if (place_pend && !cand_busy) begin
          food_x     <= cand_x;
          food_y     <= cand_y;
          place_pend <= 1'b0;
        end
        if (dir_valid && !dir_opposite) dir_pending <= dir_in;
      end
    end
  end

  // ------------------------------------------------------------- outputs
  assign snake_length = len;

  always_comb begin
    snake_x_1dim = '0;
    snake_y_1dim = '0;
    for (int i = 0; i < NSEG; i++) begin
      if (i < int'(len)) begin
        snake_x_1dim[5*i +: 5] = seg_x[i];
        snake_y_1dim[5*i +: 5] = seg_y[i];
      end
    end
  end

endmodule

// File: tb/tb_snake_engine.sv
// Self-checking bench for snake_engine. A queue-based game model runs beside
// the DUT; food placement timing is not predicted, only its legality.
module tb_snake_engine;

  logic         clk = 1'b0;
  logic         rst;
  logic         tick;
  logic [1:0]   dir_in;
  logic         dir_valid;
  logic         start;
  logic [4:0]   food_x;
  logic [4:0]   food_y;
  logic [319:0] snake_x_1dim;
  logic [319:0] snake_y_1dim;
  logic [5:0]   snake_length;
  logic [1:0]   game_state;

  snake_engine dut (
    .clk          (clk),
    .rst          (rst),
    .tick         (tick),
    .dir_in       (dir_in),
    .dir_valid    (dir_valid),
    .start        (start),
    .food_x       (food_x),
    .food_y       (food_y),
    .snake_x_1dim (snake_x_1dim),
    .snake_y_1dim (snake_y_1dim),
    .snake_length (snake_length),
    .game_state   (game_state)
  );

  always #5 clk = ~clk;

  int n_tests = 0;
  int n_fail  = 0;

  task automatic check(input string tag, input logic [319:0] got, input logic [319:0] exp);
    n_tests++;
    if (got !== exp) begin
      n_fail++;
      $display("FAIL %s: got %0h expected %0h", tag, got, exp);
    end
  endtask

  // model: 0 RUNNING, 1 DIE, 2 INITIAL; directions 0 UP 1 DOWN 2 RIGHT 3 LEFT
  int m_state;
  int bx[$];
  int by[$];
  int m_app, m_pend;
  int fx, fy;
  bit fpend;
  int pend_age;

  function automatic bit opp(int a, int b);
    return ((a >> 1) == (b >> 1)) && (a != b);
  endfunction

  task automatic m_reset();
    m_state = 2;
    bx.delete();
    by.delete();
    for (int i = 0; i < 3; i++) begin
      bx.push_back(16 - i);
      by.push_back(12);
    end
    m_app = 2; m_pend = 2;
    fx = 24; fy = 12;
    fpend = 0; pend_age = 0;
  endtask

  task automatic m_move();
    int nx, ny, lim;
    bit wall, eat, hit;
    nx = bx[0]; ny = by[0]; wall = 0; hit = 0;
    m_app = m_pend;
    case (m_pend)
      0: ny = ny - 1;
      1: ny = ny + 1;
      2: nx = nx + 1;
      default: nx = nx - 1;
    endcase
`ifdef SNAKE_WRAP_EN
    nx = (nx + 32) % 32;
    ny = (ny + 24) % 24;
`else
    wall = (nx < 0) || (nx > 31) || (ny < 0) || (ny > 23);
`endif
    if (wall) begin
      m_state = 1;
    end else begin
      eat = !fpend && (nx == fx) && (ny == fy);
      lim = eat ? bx.size() : bx.size() - 1;
      for (int i = 0; i < lim; i++)
        if (bx[i] == nx && by[i] == ny) hit = 1;
      if (hit) begin
        m_state = 1;
      end else begin
        bx.push_front(nx);
        by.push_front(ny);
        if (!(eat && bx.size() <= 63)) begin
          void'(bx.pop_back());
          void'(by.pop_back());
        end
        if (eat) begin
          fpend = 1;
          pend_age = 0;
        end
      end
    end
  endtask

  task automatic m_step(input bit t, input bit dv, input int d, input bit s);
    int old_app;
    old_app = m_app;
    if (m_state == 1 && s) begin
      m_reset();
      return;
    end
    if (m_state == 2 && s) m_state = 0;
    else if (m_state == 0 && t) m_move();
    if (dv && !opp(d, old_app)) m_pend = d;
  endtask

  task automatic observe();
    int on_body;
    if (fpend) begin
      if (food_x !== 5'(fx) || food_y !== 5'(fy)) begin
        on_body = 0;
        for (int i = 0; i < bx.size(); i++)
          if (5'(bx[i]) == food_x && 5'(by[i]) == food_y) on_body = 1;
        check("food_free", 320'(on_body), 320'(0));
        check("food_y_range", 320'(food_y <= 5'd23), 320'(1));
        fx = int'(food_x);
        fy = int'(food_y);
        fpend = 0;
      end else begin
        pend_age++;
        if (pend_age > 1024) begin
          check("place_timeout", 320'(pend_age), 320'(0));
          fpend = 0;
        end
      end
    end
  endtask

  task automatic compare();
    logic [319:0] ex, ey;
    ex = '0;
    ey = '0;
    for (int i = 0; i < bx.size(); i++) begin
      ex[5*i +: 5] = 5'(bx[i]);
      ey[5*i +: 5] = 5'(by[i]);
    end
    check("game_state", 320'(game_state), 320'(m_state));
    check("length", 320'(snake_length), 320'(bx.size()));
    check("snake_x", snake_x_1dim, ex);
    check("snake_y", snake_y_1dim, ey);
    if (!fpend) begin
      check("food_x", 320'(food_x), 320'(fx));
      check("food_y", 320'(food_y), 320'(fy));
    end
  endtask

  // called at a falling edge; returns at the next falling edge
  task automatic cyc(input bit t, input bit dv, input int d, input bit s);
    tick = t; dir_valid = dv; dir_in = 2'(d); start = s;
    @(posedge clk);
    m_step(t, dv, d, s);
    @(negedge clk);
    tick = 0; dir_valid = 0; start = 0;
    observe();
    compare();
  endtask

  task automatic do_reset();
    #2 rst = 1'b1;
    #1;
    m_reset();
    compare();
    check("rst_state", 320'(game_state), 320'(2));
    check("rst_len", 320'(snake_length), 320'(3));
    check("rst_head_x", 320'(snake_x_1dim[4:0]), 320'(16));
    check("rst_head_y", 320'(snake_y_1dim[4:0]), 320'(12));
    check("rst_tail_x", 320'(snake_x_1dim[14:10]), 320'(14));
    check("rst_food", 320'({food_x, food_y}), 320'({5'd24, 5'd12}));
    @(negedge clk);
    rst = 1'b0;
  endtask

  task automatic wait_place();
    int g;
    g = 0;
    while (fpend && g < 1100) begin
      cyc(0, 0, 0, 0);
      g++;
    end
  endtask

  function automatic int pick_dir();
    int dx, dy, d;
    dx = fx - bx[0];
    dy = fy - by[0];
    if (dx > 0)      d = 2;
    else if (dx < 0) d = 3;
    else if (dy > 0) d = 1;
    else             d = 0;
    if (opp(d, m_app)) begin
      if (d >= 2) d = (by[0] > 0) ? 0 : 1;
      else        d = (bx[0] > 0) ? 3 : 2;
    end
    return d;
  endfunction

  task automatic chase_to_len(input int target);
    int d;
    for (int k = 0; k < 300; k++) begin
      if (m_state != 0 || bx.size() >= target) break;
      wait_place();
      d = pick_dir();
      cyc(0, 1, d, 0);
      cyc(1, 0, 0, 0);
    end
  endtask

  function automatic bit step_in_grid(input int d);
    int x, y;
    x = bx[0]; y = by[0];
    case (d)
      0: y = y - 1;
      1: y = y + 1;
      2: x = x + 1;
      default: x = x - 1;
    endcase
    return (x >= 0) && (x <= 31) && (y >= 0) && (y <= 23);
  endfunction

  // three same-side turns: closes a 2x2 loop back onto the body
  task automatic loop3();
    int lt[4];
    int rt[4];
    int d;
    bit use_left;
    lt = '{3, 2, 0, 1};
    rt = '{2, 3, 1, 0};
    d = m_app;
    use_left = step_in_grid(lt[d]);
    for (int k = 0; k < 3; k++) begin
      d = use_left ? lt[d] : rt[d];
      cyc(0, 1, d, 0);
      cyc(1, 0, 0, 0);
    end
  endtask

  initial begin
    #1_000_000;
    $display("FAIL watchdog: got timeout expected finish");
    $fatal(1, "watchdog");
  end

  initial begin
    int len_b;
    rst = 1'b1; tick = 0; dir_valid = 0; dir_in = 0; start = 0;
    m_reset();
    #3;
    compare();
    check("init_state", 320'(game_state), 320'(2));
    check("init_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd16, 5'd12}));
    @(negedge clk);
    rst = 1'b0;

    // start, three plain ticks
    cyc(0, 0, 0, 1);
    repeat (3) cyc(1, 0, 0, 0);
    check("r3_state", 320'(game_state), 320'(0));
    check("r3_head_x", 320'(snake_x_1dim[4:0]), 320'(19));
    check("r3_tail_x", 320'(snake_x_1dim[14:10]), 320'(17));
    check("r3_len", 320'(snake_length), 320'(3));

    // reversal dropped, then a legal turn
    do_reset();
    cyc(0, 0, 0, 1);
    cyc(0, 1, 3, 0);
    cyc(1, 0, 0, 0);
    check("rev_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd17, 5'd12}));
    cyc(0, 1, 0, 0);
    cyc(1, 0, 0, 0);
    check("up_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd17, 5'd11}));

    // eat the reset food, then vacating-tail loop at length 4
    do_reset();
    cyc(0, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    check("eat_len", 320'(snake_length), 320'(4));
    check("eat_head_x", 320'(snake_x_1dim[4:0]), 320'(24));
    check("eat_tail_x", 320'(snake_x_1dim[19:15]), 320'(21));
    wait_place();
    len_b = bx.size();
    loop3();
    if (bx.size() == len_b) check("loop4_state", 320'(game_state), 320'(0));

    // grow to 5 and close the loop onto the body
    chase_to_len(5);
    if (m_state == 0 && bx.size() == 5) begin
      wait_place();
      loop3();
      if (bx.size() == 5) check("loop5_state", 320'(game_state), 320'(1));
    end

    // right wall
    do_reset();
    cyc(0, 0, 0, 1);
    repeat (15) cyc(1, 0, 0, 0);
    check("edge_head_x", 320'(snake_x_1dim[4:0]), 320'(31));
    cyc(1, 0, 0, 0);
`ifdef SNAKE_WRAP_EN
    check("wrap_state", 320'(game_state), 320'(0));
    check("wrap_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd0, 5'd12}));
`else
    check("wall_state", 320'(game_state), 320'(1));
    check("wall_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd31, 5'd12}));
`endif

    // restart from DIE
    if (m_state == 1) begin
      cyc(0, 0, 0, 1);
      check("restart_state", 320'(game_state), 320'(2));
      check("restart_len", 320'(snake_length), 320'(3));
      check("restart_head", 320'({snake_x_1dim[4:0], snake_y_1dim[4:0]}), 320'({5'd16, 5'd12}));
      check("restart_food", 320'({food_x, food_y}), 320'({5'd24, 5'd12}));
    end

    // reset right after an eat, while placement is pending
    do_reset();
    cyc(0, 0, 0, 1);
    repeat (8) cyc(1, 0, 0, 0);
    do_reset();

    // random play
    for (int n = 0; n < 3000; n++) begin
      if ($urandom_range(0, 199) == 0)
        do_reset();
      else
        cyc($urandom_range(0, 2) == 0, $urandom_range(0, 3) == 0,
            int'($urandom_range(0, 3)), $urandom_range(0, 15) == 0);
    end

    $display("[TB] %0d tests run, %0d failed", n_tests, n_fail);
    $finish;
  end

endmodule

// File: doc/snake_engine.md
SNAKE_ENGINE -- requirements
Module: snake_engine

Interface
REQ-001 Parameter GRID_W, default 32, meaning grid columns (cells 0..31).
REQ-002 Parameter GRID_H, default 24, meaning grid rows (cells 0..23).
REQ-003 Parameter INIT_LEN, default 3, meaning snake length after reset/restart.
REQ-004 Parameter MAX_LEN, default 63, meaning length ceiling.
REQ-005 clk  in  1  single system clock; all state on rising edge.
REQ-006 rst  in  1  asynchronous, active-high reset.
REQ-007 tick  in  1  one-cycle move strobe; one step per high cycle.
REQ-008 dir_in  in  2  requested direction: UP=00, DOWN=01, RIGHT=10, LEFT=11.
REQ-009 dir_valid  in  1  qualifies dir_in for one cycle.
REQ-010 start  in  1  one-cycle start/restart strobe.
REQ-011 food_x, food_y  out  5 each  food cell.
REQ-012 snake_x_1dim, snake_y_1dim  out  320 each  segment i at bits [5i+4:5i]; i=0 is head.
REQ-013 snake_length  out  6  active segment count.
REQ-014 game_state  out  2  RUNNING=00, DIE=01, INITIAL=10; 11 never driven.

Function
REQ-015 FSM: INITIAL --start--> RUNNING; RUNNING --collision on tick--> DIE; DIE --start--> INITIAL with snake and food re-initialised to reset values (REQ-030).
REQ-016 dir_valid in any state latches dir_in as pending direction unless it is the exact opposite of the last applied move direction; opposite requests are dropped.
REQ-017 On tick in RUNNING: apply pending direction, compute next head = head +/-1 in x or y; all outputs show the result the cycle after tick.
REQ-018 Wall: next head outside 0..GRID_W-1 or 0..GRID_H-1 -> game_state=DIE, segments, length and food unchanged.
REQ-019 Eat: next head equals food and no placement pending.
REQ-020 Self collision: next head equals any segment 0..len-2 when not eating, 0..len-1 when eating -> DIE, body unchanged; moving into the vacating tail cell is legal.
REQ-021 Legal move: segment i+1 <= segment i for i<len-1, segment 0 <= next head; on eat with len<MAX_LEN, length+1 and new last segment takes old tail; at MAX_LEN, no growth, eat still triggers placement.
REQ-022 Segments at index >= snake_length drive 0 on both buses.
REQ-023 Food placement: 10-bit maximal-length LFSR (nonzero seed, stepping every clk); candidate x=lfsr[4:0], y=lfsr[9:5], with y-8 if y>=24.
REQ-024 After eat, placement pending: each cycle the candidate is checked against all active segments (post-move body); first free candidate is loaded into food_x/food_y and pending clears.
REQ-025 While pending, food outputs hold old value and eating is suppressed; further ticks move normally.
REQ-026 tick, dir_valid and start outside stated states are ignored; start and tick in the same RUNNING cycle: tick processed, start ignored.
REQ-027 tick and dir_valid in same cycle: latched direction takes effect on the next tick, not the current one.
REQ-028 Move and placement each complete in one cycle; no stall of tick input.

Reset
REQ-029 rst asynchronously forces game_state=INITIAL, applied/pending direction=RIGHT, placement pending=0, LFSR=seed 10'h2A5.
REQ-030 Reset snake: length=INIT_LEN, head (16,12), segment i at (16-i,12), others 0; food (24,12).
REQ-031 rst mid-move or mid-placement discards it; release is sampled synchronously on next edge.

Configuration
REQ-032 Macro SNAKE_WRAP_EN: when defined, a head leaving the grid wraps to opposite edge (x 31->0, 0->31; y 23->0, 0->23) and no wall death occurs; when undefined, REQ-018 applies.

Verification
REQ-033 Reset, start, 3 ticks with no dir -> RUNNING, head (19,12), length 3, tail (17,12).
REQ-034 After reset, dir_valid LEFT then tick -> dropped, head (17,12); dir_valid UP then tick -> head (17,11).
REQ-035 Steer head into food (24,12) -> next cycle length 4, new tail = old tail; within 1024 cycles food moves to cell not on body, y<=23.
REQ-036 Run RIGHT to x=31, one more tick -> DIE, head stays (31,12); with SNAKE_WRAP_EN -> RUNNING, head (0,12).
REQ-037 Length 5, turn UP,LEFT,DOWN in loop into body -> DIE; length 4 into vacating tail cell -> stays RUNNING.
REQ-038 In DIE, start -> INITIAL, length 3, head (16,12), food (24,12); rst asserted mid-placement -> REQ-029/030 values immediately.
